// File: rtl/fp_mlp_pkg.sv
// fp_mlp_pkg: shared FSM encoding and default widths for the FP16 MLP blocks
package fp_mlp_pkg;
    localparam int FP_DATA_WIDTH = 16;
    localparam int FP_ADDR_WIDTH = 8;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } seq_state_e;
endpackage

// File: rtl/fp_mlp_sequencer.sv
// fp_mlp_sequencer: time-multiplexes one fp_mlp_layer across N_LAYERS square FP16 layers
module fp_mlp_sequencer
    import fp_mlp_pkg::*;
#(
    parameter int DATA_WIDTH     = FP_DATA_WIDTH,
    parameter int WIDTH          = 4,
    parameter int ADDR_WIDTH     = FP_ADDR_WIDTH,
    parameter int N_LAYERS       = 3,
    parameter int NEURON_LATENCY = 3,
    parameter int LIDX_W         = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_WIDTH*WIDTH-1:0]         in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_WIDTH*WIDTH-1:0]         out_data,
    output logic [LIDX_W-1:0]                   w_addr,
    input  logic [DATA_WIDTH*WIDTH*WIDTH-1:0]   w_data,
    input  logic [ADDR_WIDTH*WIDTH-1:0]         lut_data,
    output logic [DATA_WIDTH*WIDTH-1:0]         layer_inputs,
    output logic [DATA_WIDTH*WIDTH*WIDTH-1:0]   layer_weights,
    output logic [ADDR_WIDTH*WIDTH-1:0]         lut_addrs,
    input  logic [DATA_WIDTH*WIDTH-1:0]         layer_outputs,
    output logic                                busy,
    output logic [LIDX_W-1:0]                   layer_idx
);
    localparam int CNT_W = (NEURON_LATENCY > 1) ? $clog2(NEURON_LATENCY) : 1;
    localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(N_LAYERS - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NEURON_LATENCY - 1);

    seq_state_e                         state_q, state_d;
    logic [DATA_WIDTH*WIDTH-1:0]        act_q, act_d, out_q, out_d;
    logic [DATA_WIDTH*WIDTH*WIDTH-1:0]  wts_q, wts_d;
    logic [ADDR_WIDTH*WIDTH-1:0]        lut_q, lut_d;
    logic [LIDX_W-1:0]                  idx_q, idx_d, waddr_q, waddr_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic                               accept, last, capture;

    assign accept  = in_valid && in_ready;
    assign last    = idx_q == LAST_IDX;
    assign capture = state_q == S_CAPTURE;

    // State register; reset aborts any inference in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state: fixed FETCH/LOAD/WAIT/CAPTURE walk per layer, then DONE until drained
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = in_valid ? S_FETCH : S_IDLE;
            S_FETCH:   state_d = S_LOAD;
            S_LOAD:    state_d = S_WAIT;
            S_WAIT:    state_d = (cnt_q == '0) ? S_CAPTURE : S_WAIT;
            S_CAPTURE: state_d = last ? S_DONE : S_FETCH;
            S_DONE:    state_d = out_ready ? S_IDLE : S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs decode straight from state
    always_comb begin
        in_ready  = state_q == S_IDLE;
        out_valid = state_q == S_DONE;
        busy      = state_q != S_IDLE;
    end

    // Datapath next values; the memory address is registered on entry to FETCH
    always_comb begin
        act_d   = accept ? in_data : (capture ? layer_outputs : act_q);
        idx_d   = accept ? '0 : ((capture && !last) ? idx_q + LIDX_W'(1) : idx_q);
        waddr_d = (state_d == S_FETCH) ? idx_d : waddr_q;
        wts_d   = (state_q == S_LOAD) ? w_data : wts_q;
        lut_d   = (state_q == S_LOAD) ? lut_data : lut_q;
        cnt_d   = (state_q == S_LOAD) ? CNT_INIT :
                  ((state_q == S_WAIT && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q);
        out_d   = (capture && last) ? layer_outputs : out_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q   <= '0;
            idx_q   <= '0;
            waddr_q <= '0;
            wts_q   <= '0;
            lut_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            act_q   <= act_d;
            idx_q   <= idx_d;
            waddr_q <= waddr_d;
            wts_q   <= wts_d;
            lut_q   <= lut_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign layer_inputs  = act_q;
    assign layer_weights = wts_q;
    assign lut_addrs     = lut_q;
    assign out_data      = out_q;
    assign w_addr        = waddr_q;
    assign layer_idx     = idx_q;
endmodule

// File: doc/fp_mlp_sequencer.md
# fp_mlp_sequencer

Time-multiplexes a single `fp_mlp_layer` instance across `N_LAYERS` square fully-connected layers of an FP16 MLP. For each layer it fetches weights and LUT addresses from an external synchronous weight memory and drives them into the layer. It waits out the fixed neuron latency, then captures the layer outputs back into an activation register. One input vector is accepted and one result is returned per inference, via valid/ready handshakes; the sibling top `fp_mlp_core` wires this block to one `fp_mlp_layer`.

## Interface
- `DATA_WIDTH`, 16: FP word width.
- `WIDTH`, 4: inputs per neuron = neurons per layer (all layers square).
- `ADDR_WIDTH`, 8: activation-LUT address width per neuron.
- `N_LAYERS`, 3: layers per inference, ≥1.
- `NEURON_LATENCY`, 3: cycles from stable layer inputs/weights to valid layer outputs, ≥1.
- `LIDX_W`, `max(1,$clog2(N_LAYERS))`: layer index width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1, `in_ready` out 1, `in_data` in `DATA_WIDTH*WIDTH`: input vector.
- `out_valid` out 1, `out_ready` in 1, `out_data` out `DATA_WIDTH*WIDTH`: result vector.
- `w_addr` out `LIDX_W`: weight-memory layer address; data returns 1 cycle later.
- `w_data` in `DATA_WIDTH*WIDTH*WIDTH`: weights for addressed layer.
- `lut_data` in `ADDR_WIDTH*WIDTH`: LUT addresses for addressed layer.
- `layer_inputs` out `DATA_WIDTH*WIDTH`, `layer_weights` out `DATA_WIDTH*WIDTH*WIDTH`, `lut_addrs` out `ADDR_WIDTH*WIDTH`: drive `fp_mlp_layer`.
- `layer_outputs` in `DATA_WIDTH*WIDTH`: from `fp_mlp_layer`.
- `busy` out 1: high in any state except IDLE.
- `layer_idx` out `LIDX_W`: current layer.

## Operation
- FSM states: IDLE, FETCH, LOAD, WAIT, CAPTURE, DONE.
- IDLE:
  - `in_ready`=1 (combinational from state).
  - On `in_valid&&in_ready`: the activation register takes `in_data`, `layer_idx`←0, next state FETCH.
- FETCH (1 cycle): `w_addr`=`layer_idx` (registered).
- LOAD (1 cycle):
  - `layer_weights`←`w_data` and `lut_addrs`←`lut_data`, registered at the end of the cycle.
  - The wait counter is loaded with `NEURON_LATENCY-1`.
- WAIT: holds for `NEURON_LATENCY` cycles, decrementing to 0.
- CAPTURE (1 cycle):
  - The activation register takes `layer_outputs`.
  - If `layer_idx==N_LAYERS-1`: `out_data`←`layer_outputs`, next state DONE.
  - Otherwise: `layer_idx`+1, next state FETCH.
- DONE:
  - `out_valid`=1; `out_data`, `layer_weights` and `lut_addrs` are held.
  - On `out_ready`: next state IDLE.
- `layer_inputs` is driven continuously from the activation register. It changes only on input accept or in CAPTURE, so it is stable through LOAD/WAIT.
- No arithmetic is performed here; all data words pass through bit-exact.

## Timing
- Reset values (while `rst`=0):
  - State IDLE.
  - `out_valid`, `busy`, `layer_idx`, `w_addr`, wait counter: 0.
  - `out_data`, `layer_inputs`, `layer_weights`, `lut_addrs`: all-zero.
- During reset `in_ready` evaluates 1, but no handshake is taken while `rst`=0.
- Per-layer cost is `NEURON_LATENCY+3` cycles.
- Latency: `out_valid` rises `N_LAYERS*(NEURON_LATENCY+3)` cycles after the accept edge; 18 with defaults.
- `w_data`/`lut_data` are sampled only at the LOAD edge. Changes at any other time have no effect.
- `out_ready` held low: stay in DONE indefinitely with outputs stable; `in_ready`=0.
- DONE→IDLE takes one cycle:
  - `in_ready` is 1 on the cycle after the output handshake.
  - Output handshake and next input accept never occur in the same cycle.
- `in_valid` is ignored outside IDLE; `out_ready` is ignored outside DONE.
- Reset asserted mid-inference aborts immediately to reset values. The partial result is discarded and never presented.
- `N_LAYERS`=1: FETCH→LOAD→WAIT→CAPTURE→DONE once; `layer_idx` stays 0.

## Structure
- Shared package `fp_mlp_pkg` holds:
  - FSM state encoding.
  - Default `DATA_WIDTH`/`ADDR_WIDTH` constants, common with `fp_mlp_layer`/`fp_neuron`.
- No internal sub-module: the datapath `fp_mlp_layer` stays external, instantiated beside this block in `fp_mlp_core`.

## Test plan
- Defaults; bench layer model = identity after 3 cycles; accept `in_data`={16'h3C00,16'h4000,16'h4200,16'h4400} at cycle 0 → `out_valid` at cycle 18; `out_data` equals the input; `w_addr` sequence 0,1,2 in successive FETCH states.
- Memory layer k returns weights 16'h1000+k, LUT addr 8'h10+k; bench toggles `w_data` during WAIT → `layer_weights` equals 16'h1000+k from LOAD through CAPTURE of layer k only.
- Hold `out_ready`=0 for 5 cycles after `out_valid` → `out_data` stable, `in_ready`=0, `busy`=1; `out_ready`=1 → IDLE next cycle, `busy`=0.
- `in_valid` held high with two vectors → second accepted exactly 1 cycle after the first output handshake; results in order.
- Assert `rst`=0 during WAIT of layer 1 → all outputs at reset values in the same cycle; after release, a new input completes in 18 cycles starting from `w_addr`=0.
- `N_LAYERS`=1, `NEURON_LATENCY`=1 → `out_valid` 4 cycles after accept.
